// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - frame-synchronous game flow: buttons, lives, invulnerability, run gating
// Define GAME_CTRL_DEBOUNCE_EN for full button debounce; undefined uses the bare 2-FF synchronised level.
module game_ctrl #(
  parameter int DB_CYCLES  = 1000000,
  parameter int LIVES      = 3,
  parameter int INV_FRAMES = 60
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start_btn,
  input  logic        i_pause_btn,
  input  logic        i_animate,
  input  logic        i_hit,
  output logic [1:0]  o_state,
  output logic        o_run,
  output logic [2:0]  o_lives,
  output logic        o_ship_vis,
  output logic [15:0] o_frame_cnt
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_PAUSE = 2'd2, S_OVER = 2'd3} state_t;

  // Assert asynchronously, release synchronously.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [1:0] btn_raw;
  logic [1:0] press;
  logic       start_press;
  logic       pause_press;

  assign btn_raw     = {i_pause_btn, i_start_btn};
  assign start_press = press[0];
  assign pause_press = press[1];

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [1:0] sync;
    logic       db;
    logic       db_next;
    logic       pulse;

    always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) sync <= 2'b00;
      else        sync <= {sync[0], btn_raw[b]};
    end

`ifdef GAME_CTRL_DEBOUNCE_EN
    localparam int DBW = $clog2(DB_CYCLES + 1);
    logic [DBW-1:0] cnt;
    logic           cnt_done;

    assign cnt_done = (cnt == DBW'(DB_CYCLES - 1));
    assign db_next  = (sync[1] != db && cnt_done) ? sync[1] : db;

    always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n)                        cnt <= '0;
      else if (sync[1] == db || cnt_done) cnt <= '0;
      else                               cnt <= cnt + 1'b1;
    end
`else
    assign db_next = sync[1];
`endif

    always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
        db    <= 1'b0;
        pulse <= 1'b0;
      end else begin
        db    <= db_next;
        pulse <= db_next & ~db;
      end
    end
    assign press[b] = pulse;
  end

  state_t      state, state_n;
  logic [2:0]  lives, lives_n;
  logic [7:0]  inv_cnt, inv_n;
  logic [15:0] frame_cnt, fcnt_n;
  logic        run;
  logic        req_start, req_pause, req_hit;
  logic        req_start_n, req_pause_n, req_hit_n;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lives     <= '0;
      inv_cnt   <= '0;
      frame_cnt <= '0;
      run       <= 1'b0;
      req_start <= 1'b0;
      req_pause <= 1'b0;
      req_hit   <= 1'b0;
    end else begin
      state     <= state_n;
      lives     <= lives_n;
      inv_cnt   <= inv_n;
      frame_cnt <= fcnt_n;
      run       <= (state_n == S_PLAY);
      req_start <= req_start_n;
      req_pause <= req_pause_n;
      req_hit   <= req_hit_n;
    end
  end

  // Requests are consumed at the frame strobe; a press on that same cycle survives into the next frame.
  always_comb begin
    state_n     = state;
    lives_n     = lives;
    inv_n       = inv_cnt;
    fcnt_n      = frame_cnt;
    req_start_n = (req_start & ~i_animate) | start_press;
    req_pause_n = (req_pause & ~i_animate) | pause_press;
    req_hit_n   = (req_hit & ~i_animate) | i_hit;
    if (i_animate) begin
      case (state)
        S_IDLE: if (req_start) begin
          state_n = S_PLAY;
          lives_n = 3'(LIVES);
          fcnt_n  = '0;
          inv_n   = '0;
        end
        S_PLAY: begin
          fcnt_n = frame_cnt + 16'd1;
          if (req_hit && inv_cnt == 8'd0) begin
            lives_n = lives - 3'd1;
            inv_n   = 8'(INV_FRAMES);
            if (lives == 3'd1)  state_n = S_OVER;
            else if (req_pause) state_n = S_PAUSE;
          end else begin
            if (inv_cnt != 8'd0) inv_n = inv_cnt - 8'd1;
            if (req_pause)       state_n = S_PAUSE;
          end
        end
        S_PAUSE: if (req_pause) state_n = S_PLAY;
        S_OVER:  if (req_start) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign o_state     = state;
  assign o_run       = run;
  assign o_lives     = lives;
  assign o_frame_cnt = frame_cnt;
  assign o_ship_vis  = (inv_cnt == 8'd0) || inv_cnt[2];

endmodule
